alu_sequencer: RTL
==================

// Module: alu_sequencer
// PURPOSE
//  Command-side controller that drives the combinational 8-bit ALU. Holds operand
//  registers A/B, loads them from switch data, issues an op, and captures the result.
//  Does the ALU's register-side ops itself (swap, store A, load A from switches).
//  Sits between the switch/button front end and the ALU; ALU is external via alu_* ports.
// PARAMETERS
//  WIDTH   8   operand/result width (must match ALU)
//  OPW     4   op code width
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  cmd_valid  in   1      command request; held until accepted
//  cmd_ready  out  1      high only in IDLE; accept = cmd_valid & cmd_ready
//  cmd        in   2      00 LOAD_A, 01 LOAD_B, 10 EXEC, 11 CLEAR
//  cmd_op     in   OPW    ALU op code, used by EXEC
//  cmd_wb     in   1      EXEC: also write result into A (accumulate)
//  sw_data    in   WIDTH  switch data for LOAD_A/LOAD_B/op 1111
//  alu_a      out  WIDTH  = reg A (continuous)
//  alu_b      out  WIDTH  = reg B (continuous)
//  alu_op     out  OPW    registered op under issue
//  alu_y      in   WIDTH  ALU combinational result
//  result     out  WIDTH  registered result
//  done       out  1      one-cycle pulse when command completes
// BEHAVIOUR
//  - Reset (async): A=B=result=0, alu_op=0, done=0, state=IDLE, cmd_ready=1.
//  - States: IDLE, ISSUE, CAPTURE. cmd_ready=1 only in IDLE.
//  - LOAD_A/LOAD_B: on accept A (resp. B)<=sw_data; stay IDLE; done pulses next cycle;
//    result unchanged. 1-cycle latency.
//  - CLEAR: A=B=result<=0 on accept; done next cycle; stay IDLE.
//  - EXEC: on accept alu_op<=cmd_op, wb flag latched, IDLE->ISSUE. ISSUE: ALU settles,
//    ->CAPTURE. CAPTURE: do op-specific update, done=1, ->IDLE. done 2 cycles after accept.
//  - EXEC op handling in CAPTURE:
//    * 0000-1100: result<=alu_y; if wb A<=alu_y.
//    * 1101 store A: result<=A.
//    * 1110 swap: A<=B, B<=A, result<=old B (sequencer owns B; ALU never writes it).
//    * 1111 load A: A<=sw_data sampled in CAPTURE, result<=same value.
//    wb ignored for 1101/1110/1111.
//  - Arithmetic wraps mod 2^WIDTH (done in ALU); no carry/overflow kept.
//  - cmd, cmd_op, cmd_wb sampled only at accept; changes while busy ignored.
//  - cmd_valid while busy: not accepted, no loss; accepted on first IDLE cycle.
//  - Back-to-back: a command presented with done can be accepted that cycle (IDLE).
//  - Reset mid-EXEC: command aborted, no done, all regs to reset values.
//  - alu_op holds last issued op in IDLE.
// CONFIGURATION
//  ALU_FLAGS_EN defined: add outputs flag_z (result==0) and flag_n (result[WIDTH-1]),
//   registered with result, reset 0, updated only where result updates.
//  Undefined: ports absent, no flag logic.
// TESTING
//  1 Reset mid-EXEC: rst in ISSUE -> result=0, A=B=0, no done, cmd_ready=1.
//  2 LOAD_A 0x0C, LOAD_B 0x05, EXEC op 0000 -> result=0x11, done 2 cycles after
//    accept, A stays 0x0C.
//  3 A=0x05, B=0x0C, EXEC op 0001 wb=1 -> result=0xF9, A=0xF9 (wrap).
//  4 A=0x3A, B=0xC5, EXEC op 1110 -> A=0xC5, B=0x3A, result=0xC5.
//  5 cmd_valid held during EXEC (LOAD_B 0x77) -> cmd_ready=0 in ISSUE/CAPTURE,
//    LOAD_B accepted on first IDLE cycle, B=0x77, exactly two done pulses.
//  6 ALU_FLAGS_EN: A=B=0x42, EXEC op 0111 -> result=0, flag_z=1, flag_n=0;
//    then op 1100 with A=0x01 -> result=0xFF, flag_n=1.

Source files
------------

// File: rtl/alu_sequencer.sv
// Command sequencer for an external combinational ALU: owns operand registers A/B,
// issues ops, captures results. Optional status flags under `ALU_FLAGS_EN`.
module alu_sequencer #(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [1:0]       i_cmd,
    input  logic [OPW-1:0]   i_cmd_op,
    input  logic             i_cmd_wb,
    input  logic [WIDTH-1:0] i_sw_data,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    output logic [OPW-1:0]   o_alu_op,
    input  logic [WIDTH-1:0] i_alu_y,
    output logic [WIDTH-1:0] o_result,
    output logic             o_done
`ifdef ALU_FLAGS_EN
    ,
    output logic             o_flag_z,
    output logic             o_flag_n
`endif
);

    localparam logic [1:0] CMD_LOAD_A = 2'b00;
    localparam logic [1:0] CMD_LOAD_B = 2'b01;
    localparam logic [1:0] CMD_EXEC   = 2'b10;
    localparam logic [1:0] CMD_CLEAR  = 2'b11;

    // Register-side ops occupy the top three codes; the ALU's own output is ignored for them.
    localparam logic [OPW-1:0] OP_STORE_A = {{(OPW-2){1'b1}}, 2'b01};
    localparam logic [OPW-1:0] OP_SWAP    = {{(OPW-1){1'b1}}, 1'b0};
    localparam logic [OPW-1:0] OP_LOAD_A  = {OPW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ISSUE   = 2'b01,
        ST_CAPTURE = 2'b10
    } state_t;

    state_t             r_state;
    logic               r_cmd_ready;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [OPW-1:0]     r_alu_op;
    logic               r_wb;
    logic [WIDTH-1:0]   r_result;
    logic               r_done;

    logic               w_accept;
    logic               w_res_we;
    logic [WIDTH-1:0]   w_res_nxt;

    assign w_accept    = i_cmd_valid & r_cmd_ready;
    assign o_cmd_ready = r_cmd_ready;
    assign o_alu_a     = r_a;
    assign o_alu_b     = r_b;
    assign o_alu_op    = r_alu_op;
    assign o_result    = r_result;
    assign o_done      = r_done;

    // Next result value and its write enable, shared by the result and flag registers.
    always_comb begin
        w_res_we  = 1'b0;
        w_res_nxt = r_result;
        if (r_state == ST_IDLE) begin
            if (w_accept && (i_cmd == CMD_CLEAR)) begin
                w_res_we  = 1'b1;
                w_res_nxt = {WIDTH{1'b0}};
            end else begin
                w_res_we  = 1'b0;
            end
        end else if (r_state == ST_CAPTURE) begin
            w_res_we = 1'b1;
            case (r_alu_op)
                OP_STORE_A: w_res_nxt = r_a;
                OP_SWAP:    w_res_nxt = r_b;
                OP_LOAD_A:  w_res_nxt = i_sw_data;
                default:    w_res_nxt = i_alu_y;
            endcase
        end else begin
            w_res_we = 1'b0;
        end
    end

    // Control FSM with operand, op and result registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_a         <= {WIDTH{1'b0}};
            r_b         <= {WIDTH{1'b0}};
            r_alu_op    <= {OPW{1'b0}};
            r_wb        <= 1'b0;
            r_result    <= {WIDTH{1'b0}};
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_res_we) begin
                r_result <= w_res_nxt;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (i_cmd)
                            CMD_LOAD_A: begin
                                r_a    <= i_sw_data;
                                r_done <= 1'b1;
                            end
                            CMD_LOAD_B: begin
                                r_b    <= i_sw_data;
                                r_done <= 1'b1;
                            end
                            CMD_EXEC: begin
                                r_alu_op    <= i_cmd_op;
                                r_wb        <= i_cmd_wb;
                                r_cmd_ready <= 1'b0;
                                r_state     <= ST_ISSUE;
                            end
                            CMD_CLEAR: begin
                                r_a    <= {WIDTH{1'b0}};
                                r_b    <= {WIDTH{1'b0}};
                                r_done <= 1'b1;
                            end
                            default: r_state <= ST_IDLE;
                        endcase
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    case (r_alu_op)
                        OP_STORE_A: r_a <= r_a;
                        OP_SWAP: begin
                            r_a <= r_b;
                            r_b <= r_a;
                        end
                        OP_LOAD_A: r_a <= i_sw_data;
                        default: begin
                            if (r_wb) begin
                                r_a <= i_alu_y;
                            end
                        end
                    endcase
                    r_done      <= 1'b1;
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_FLAGS_EN
    logic r_flag_z;
    logic r_flag_n;

    assign o_flag_z = r_flag_z;
    assign o_flag_n = r_flag_n;

    // Flags follow the result register: they move only when the result is written.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
        end else if (w_res_we) begin
            r_flag_z <= (w_res_nxt == {WIDTH{1'b0}});
            r_flag_n <= w_res_nxt[WIDTH-1];
        end
    end
`endif

endmodule
